// File: rtl/concentrator_pkg.sv
// Shared packet-word geometry and byte codes for the bridge packet path.
// Both the concentrator and the distributor build on these definitions.
package concentrator_pkg;

    localparam int PFW_SZ         = 69;
    localparam int PFW_CODE_LSB   = 67;
    localparam int PFW_IDX_LSB    = 64;
    localparam int BYTES_PER_WORD = 8;

    localparam logic [1:0] PCC_MOP  = 2'b00;
    localparam logic [1:0] PCC_SOP  = 2'b01;
    localparam logic [1:0] PCC_EOP  = 2'b10;
    localparam logic [1:0] PCC_BOTH = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } cc_state_t;

    // Byte 0 of a word occupies the most significant lane.
    function automatic logic [63:0] place_byte(
        input logic [63:0] acc,
        input logic [2:0]  idx,
        input logic [7:0]  b
    );
        logic [63:0] w_res;
        w_res = acc;
        w_res[8*(7-int'(idx)) +: 8] = b;
        return w_res;
    endfunction

endpackage

// File: rtl/concentrator_sd_output.sv
// Single-entry output holding register with srdy/drdy handshake on both sides.
// A load and a drain in the same cycle are both honoured; the new word wins.
module sd_output
    import concentrator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p_srdy,
    output logic              p_drdy,
    input  logic [PFW_SZ-1:0] p_data,
    output logic              n_srdy,
    input  logic              n_drdy,
    output logic [PFW_SZ-1:0] n_data
);

    logic              r_valid;
    logic [PFW_SZ-1:0] r_data;

    assign p_drdy = ~r_valid | n_drdy;
    assign n_srdy = r_valid;
    assign n_data = r_data;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (p_srdy & p_drdy) begin
            r_valid <= 1'b1;
        end else if (n_drdy) begin
            r_valid <= 1'b0;
        end
    end

    // NOTE: the data register is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (p_srdy & p_drdy) begin
            r_data <= p_data;
        end
    end

endmodule

// File: rtl/concentrator.sv
// Receive-side byte-to-word concentrator: packs coded bytes into 8-byte
// packet FIFO words tagged with SOP/EOP and the index of the last valid byte.
module concentrator
    import concentrator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              c_srdy,
    output logic              c_drdy,
    input  logic [1:0]        c_code,
    input  logic [7:0]        c_data,
    output logic              prx_srdy,
    input  logic              prx_drdy,
    output logic [PFW_SZ-1:0] prx_data,
    output logic              proto_err
);

    cc_state_t   r_state;
    logic [2:0]  r_idx;
    logic [63:0] r_acc;
    logic        r_first;
    logic        r_proto_err;

    cc_state_t   w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic [63:0] w_acc_nxt;
    logic        w_first_nxt;
    logic        w_keep;
    logic        w_complete;
    logic        w_err;
    logic [2:0]  w_place_idx;
    logic [63:0] w_base;
    logic [63:0] w_filled;
    logic        w_word_sop;
    logic        w_beat;
    logic        w_out_ready;
    logic [PFW_SZ-1:0] w_word;

    assign w_beat    = c_srdy & c_drdy;
    assign c_drdy    = ~w_complete | w_out_ready;
    assign proto_err = r_proto_err;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_keep      = 1'b0;
        w_complete  = 1'b0;
        w_err       = 1'b0;
        w_place_idx = r_idx;
        w_base      = r_acc;
        w_word_sop  = r_first;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        w_first_nxt = r_first;

        // Any SOP restarts the word; inside a packet that also flags the abandoned one.
        if (c_code[0]) begin
            w_keep      = 1'b1;
            w_err       = (r_state == ST_BODY);
            w_place_idx = 3'd0;
            w_base      = '0;
            w_word_sop  = 1'b1;
            w_complete  = c_code[1];
        end else if (r_state == ST_BODY) begin
            w_keep     = 1'b1;
            w_complete = c_code[1] | (r_idx == 3'd7);
        end else begin
            w_err = 1'b1;
        end

        w_filled = place_byte(w_base, w_place_idx, c_data);
        w_word   = {c_code[1], w_word_sop, w_place_idx, w_filled};

        if (w_beat & w_keep) begin
            if (w_complete) begin
                w_idx_nxt   = 3'd0;
                w_acc_nxt   = '0;
                w_first_nxt = 1'b0;
                w_state_nxt = c_code[1] ? ST_IDLE : ST_BODY;
            end else begin
                w_idx_nxt   = w_place_idx + 3'd1;
                w_acc_nxt   = w_filled;
                w_first_nxt = w_word_sop;
                w_state_nxt = ST_BODY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_acc       <= '0;
            r_first     <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_acc       <= w_acc_nxt;
            r_first     <= w_first_nxt;
            r_proto_err <= w_beat & w_err;
        end
    end

    sd_output u_sd_output (
        .clk    (clk),
        .reset  (reset),
        .p_srdy (w_beat & w_complete),
        .p_drdy (w_out_ready),
        .p_data (w_word),
        .n_srdy (prx_srdy),
        .n_drdy (prx_drdy),
        .n_data (prx_data)
    );

endmodule

// File: tb/tb_concentrator.sv
// Self-checking bench for concentrator: a packet-level byte-queue model checked
// every cycle, plus literal expectations for the directed packet scenarios.
module tb_concentrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_srdy;
    logic        c_drdy;
    logic [1:0]  c_code;
    logic [7:0]  c_data;
    logic        prx_srdy;
    logic        prx_drdy;
    logic [68:0] prx_data;
    logic        proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;
    logic [68:0] got[$];

    // Reference model state (packet view: bytes of the word being built).
    logic [7:0]  m_bytes[$];
    bit          m_in_pkt  = 0;
    bit          m_has_sop = 0;
    bit          m_valid   = 0;
    bit          m_err     = 0;
    logic [68:0] m_word    = '0;

    concentrator dut (
        .clk       (clk),
        .reset     (reset),
        .c_srdy    (c_srdy),
        .c_drdy    (c_drdy),
        .c_code    (c_code),
        .c_data    (c_data),
        .prx_srdy  (prx_srdy),
        .prx_drdy  (prx_drdy),
        .prx_data  (prx_data),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle-level compare against the model, then advance the model past the next edge.
    always @(negedge clk) begin
        bit completing, exp_drdy, beat, kept, loaded, new_err;
        logic [63:0] d;
        if (reset) begin
            m_bytes.delete();
            m_in_pkt  = 0;
            m_has_sop = 0;
            m_valid   = 0;
            m_err     = 0;
        end else begin
            completing = (c_code == 2'b11) ||
                         (m_in_pkt && (c_code == 2'b10 || (c_code == 2'b00 && m_bytes.size() == 7)));
            exp_drdy = !completing || !m_valid || prx_drdy;
            check("c_drdy", {68'b0, c_drdy}, {68'b0, exp_drdy});
            check("prx_srdy", {68'b0, prx_srdy}, {68'b0, m_valid});
            if (m_valid) check("prx_data", prx_data, m_word);
            check("proto_err", {68'b0, proto_err}, {68'b0, m_err});
            if (prx_srdy && prx_drdy) got.push_back(prx_data);
            if (proto_err) err_cnt++;

            beat    = c_srdy && exp_drdy;
            kept    = 0;
            loaded  = 0;
            new_err = 0;
            if (beat) begin
                if (c_code[0]) begin
                    new_err = m_in_pkt;
                    m_bytes.delete();
                    m_has_sop = 1;
                    m_in_pkt  = 1;
                    m_bytes.push_back(c_data);
                    kept = 1;
                end else if (m_in_pkt) begin
                    m_bytes.push_back(c_data);
                    kept = 1;
                end else begin
                    new_err = 1;
                end
                if (kept && (c_code[1] || m_bytes.size() == 8)) begin
                    d = '0;
                    for (int i = 0; i < m_bytes.size(); i++) d[63-8*i -: 8] = m_bytes[i];
                    m_word    = {c_code[1], m_has_sop, 3'(m_bytes.size() - 1), d};
                    loaded    = 1;
                    m_bytes.delete();
                    m_has_sop = 0;
                    m_in_pkt  = !c_code[1];
                end
            end
            m_err = new_err;
            if (loaded) m_valid = 1;
            else if (m_valid && prx_drdy) m_valid = 0;
        end
    end

    task automatic idle(input int n);
        c_srdy = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one byte and hold it until accepted (bounded).
    task automatic send(input logic [1:0] code, input logic [7:0] d);
        bit acc;
        int n = 0;
        c_srdy = 1'b1;
        c_code = code;
        c_data = d;
        do begin
            @(negedge clk);
            acc = c_drdy;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 69'd0, 69'd1);
        c_srdy = 1'b0;
        c_code = 2'b00;
    endtask

    initial begin
        int e0;
        reset    = 1'b1;
        c_srdy   = 1'b0;
        c_code   = 2'b00;
        c_data   = 8'h00;
        prx_drdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_prx_srdy", {68'b0, prx_srdy}, 69'd0);
        check("rst_proto_err", {68'b0, proto_err}, 69'd0);
        check("rst_c_drdy", {68'b0, c_drdy}, 69'd1);
        @(posedge clk); #1;

        // 1: full single-word packet
        got.delete();
        send(2'b01, 8'h01);
        for (int i = 2; i <= 7; i++) send(2'b00, 8'(i));
        send(2'b10, 8'h08);
        @(negedge clk);
        check("t1_latency", {68'b0, prx_srdy}, 69'd1);
        @(posedge clk); #1;
        idle(2);
        check("t1_count", 69'(got.size()), 69'd1);
        if (got.size() >= 1) check("t1_word", got[0], {2'b11, 3'd7, 64'h0102030405060708});

        // 2: 11-byte packet over two words
        got.delete();
        send(2'b01, 8'hA0);
        for (int i = 1; i <= 9; i++) send(2'b00, 8'hA0 + 8'(i));
        send(2'b10, 8'hAA);
        idle(3);
        check("t2_count", 69'(got.size()), 69'd2);
        if (got.size() >= 2) begin
            check("t2_word1", got[0], {2'b01, 3'd7, 64'hA0A1A2A3A4A5A6A7});
            check("t2_word2", got[1], {2'b10, 3'd2, 64'hA8A9AA0000000000});
        end

        // 3: single-byte packet, FSM stays idle (a following MOP is an error)
        got.delete();
        send(2'b11, 8'h5C);
        idle(2);
        check("t3_count", 69'(got.size()), 69'd1);
        if (got.size() >= 1) check("t3_word", got[0], {2'b11, 3'd0, 64'h5C00000000000000});
        send(2'b00, 8'h44);
        @(negedge clk);
        check("t3_idle_err", {68'b0, proto_err}, 69'd1);
        @(posedge clk); #1;

        // 4: stray MOP, then SOP interrupted by a second SOP
        got.delete();
        e0 = err_cnt;
        send(2'b00, 8'h33);
        idle(2);
        check("t4_stray_err", 69'(err_cnt - e0), 69'd1);
        check("t4_stray_noword", 69'(got.size()), 69'd0);
        e0 = err_cnt;
        send(2'b01, 8'h11);
        send(2'b00, 8'h22);
        send(2'b01, 8'h77);
        send(2'b10, 8'h88);
        idle(3);
        check("t4_err_once", 69'(err_cnt - e0), 69'd1);
        check("t4_count", 69'(got.size()), 69'd1);
        if (got.size() >= 1) check("t4_word", got[0], {2'b11, 3'd1, 64'h7788000000000000});

        // 5: backpressure over a 16-byte packet
        got.delete();
        prx_drdy = 1'b0;
        send(2'b01, 8'h10);
        for (int i = 1; i <= 14; i++) send(2'b00, 8'h10 + 8'(i));
        c_srdy = 1'b1;
        c_code = 2'b10;
        c_data = 8'h1F;
        repeat (3) begin
            @(negedge clk);
            check("t5_stall_drdy", {68'b0, c_drdy}, 69'd0);
            check("t5_hold_data", prx_data, {2'b01, 3'd7, 64'h1011121314151617});
            @(posedge clk); #1;
        end
        prx_drdy = 1'b1;
        send(2'b10, 8'h1F);
        idle(3);
        check("t5_count", 69'(got.size()), 69'd2);
        if (got.size() >= 2) begin
            check("t5_word1", got[0], {2'b01, 3'd7, 64'h1011121314151617});
            check("t5_word2", got[1], {2'b10, 3'd7, 64'h18191A1B1C1D1E1F});
        end

        // 6: reset mid-packet with a word still presented
        prx_drdy = 1'b0;
        send(2'b11, 8'h99);
        send(2'b01, 8'h40);
        send(2'b00, 8'h41);
        send(2'b00, 8'h42);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_rst_srdy", {68'b0, prx_srdy}, 69'd0);
        @(posedge clk); #1;
        prx_drdy = 1'b1;
        got.delete();
        send(2'b01, 8'h50);
        for (int i = 1; i <= 6; i++) send(2'b00, 8'h50 + 8'(i));
        send(2'b10, 8'h57);
        idle(3);
        check("t6_count", 69'(got.size()), 69'd1);
        if (got.size() >= 1) check("t6_word", got[0], {2'b11, 3'd7, 64'h5051525354555657});

        // Randomized traffic against the model
        repeat (4000) begin
            int r;
            r        = int'($urandom_range(0, 9));
            c_srdy   = ($urandom_range(0, 3) != 0);
            c_code   = (r < 2) ? 2'b01 : (r < 4) ? 2'b10 : (r == 4) ? 2'b11 : 2'b00;
            c_data   = 8'($urandom);
            prx_drdy = ($urandom_range(0, 3) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        reset    = 1'b0;
        prx_drdy = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
